countdown_timer: RTL and testbench



---
 rtl/countdown_pkg.sv | 25 ++
 rtl/bcd_down_digit.sv | 43 ++++
 rtl/countdown_timer.sv | 185 ++++++++++++++++++
 tb/tb_countdown_timer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// -----------------------------------------------------------------------------
// countdown_pkg
// Shared definitions for the mm:ss countdown timer.
//   state_t    : FSM state encoding (IDLE, RUN, PAUSE, DONE)
//   UNITS_MAX  : largest legal BCD units digit (seconds/minutes units)
//   TENS_MAX   : largest legal BCD tens digit (seconds/minutes tens)
//   sat_bcd    : clamps a preset nibble to a digit's legal maximum
// -----------------------------------------------------------------------------
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int UNITS_MAX = 9;
    localparam int TENS_MAX  = 5;

    function automatic logic [3:0] sat_bcd(input logic [3:0] val, input logic [3:0] max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// -----------------------------------------------------------------------------
// bcd_down_digit
// One BCD down-counting digit with synchronous load and borrow chaining.
//   clk        in   clock, rising edge
//   rstn       in   asynchronous active-low reset (digit -> 0)
//   load       in   copy load_val (saturated to MAX) into the digit
//   load_val   in   4-bit BCD preset
//   dec        in   borrow in: decrement this digit by one
//   digit      out  registered digit value, 0..MAX
//   borrow_out out  dec while the digit is 0 (the digit wraps to MAX)
// -----------------------------------------------------------------------------
module bcd_down_digit
    import countdown_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic [3:0] digit,
    output logic       borrow_out
);

    localparam logic [3:0] LP_MAX = 4'(MAX);

    logic [3:0] r_digit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_digit <= 4'd0;
        end else if (load) begin
            r_digit <= sat_bcd(load_val, LP_MAX);
        end else if (dec) begin
            r_digit <= (r_digit == 4'd0) ? LP_MAX : (r_digit - 4'd1);
        end
    end

    assign digit      = r_digit;
    assign borrow_out = dec && (r_digit == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
// Programmable mm:ss countdown timer with a one-second prescaler.
//   Parameters
//     TICKS_PER_SEC  clk cycles per one-second decrement
//     PCW            prescaler width, 2^PCW >= TICKS_PER_SEC
//   Ports
//     clk            in   clock, rising edge
//     rstn           in   asynchronous active-low reset
//     load           in   pulse: load saturated preset, go IDLE (wins over start_stop)
//     start_stop     in   pulse: start / pause / resume / acknowledge expiry
//     preset0..3     in   BCD preset: ss units, ss tens, mm units, mm tens
//     count0..3      out  registered BCD count, same digit order as presets
//     running        out  registered, high while in RUN
//     done           out  registered, high while in DONE
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | preset loaded or acknowledged; waits for start_stop
// RUN   | prescaler counting, one-second ticks decrement mm:ss
// PAUSE | prescaler and count frozen, partial second retained
// DONE  | reached 00:00; waits for start_stop to acknowledge
// -----------------------------------------------------------------------------
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int PCW           = 26
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       load,
    input  logic       start_stop,
    input  logic [3:0] preset0,
    input  logic [3:0] preset1,
    input  logic [3:0] preset2,
    input  logic [3:0] preset3,
    output logic [3:0] count0,
    output logic [3:0] count1,
    output logic [3:0] count2,
    output logic [3:0] count3,
    output logic       running,
    output logic       done
);

    localparam logic [PCW-1:0] LP_TICK_LAST = PCW'(TICKS_PER_SEC - 1);

    state_t         r_state;
    state_t         w_state_n;
    logic [PCW-1:0] r_presc;
    logic [PCW-1:0] w_presc_n;
    logic           r_running;
    logic           r_done;

    logic [3:0]     w_dig0;
    logic [3:0]     w_dig1;
    logic [3:0]     w_dig2;
    logic [3:0]     w_dig3;
    logic [3:0]     w_borrow;
    logic           w_tick;
    logic           w_dec0;
    logic           w_zero;
    logic           w_at_one;
    logic           w_expire;

    // ---------------- digit chain ----------------
    bcd_down_digit #(.MAX(UNITS_MAX)) u_dig0 (
        .clk        (clk),
        .rstn       (rstn),
        .load       (load),
        .load_val   (preset0),
        .dec        (w_dec0),
        .digit      (w_dig0),
        .borrow_out (w_borrow[0])
    );

    bcd_down_digit #(.MAX(TENS_MAX)) u_dig1 (
        .clk        (clk),
        .rstn       (rstn),
        .load       (load),
        .load_val   (preset1),
        .dec        (w_borrow[0]),
        .digit      (w_dig1),
        .borrow_out (w_borrow[1])
    );

    bcd_down_digit #(.MAX(UNITS_MAX)) u_dig2 (
        .clk        (clk),
        .rstn       (rstn),
        .load       (load),
        .load_val   (preset2),
        .dec        (w_borrow[1]),
        .digit      (w_dig2),
        .borrow_out (w_borrow[2])
    );

    bcd_down_digit #(.MAX(TENS_MAX)) u_dig3 (
        .clk        (clk),
        .rstn       (rstn),
        .load       (load),
        .load_val   (preset3),
        .dec        (w_borrow[2]),
        .digit      (w_dig3),
        .borrow_out (w_borrow[3])
    );

    // ---------------- tick and zero detect ----------------
    assign w_zero   = ({w_dig3, w_dig2, w_dig1, w_dig0} == 16'h0000);
    assign w_at_one = ({w_dig3, w_dig2, w_dig1, w_dig0} == 16'h0001);
    assign w_tick   = (r_state == RUN) && (r_presc == LP_TICK_LAST);

    // 00:00 is never decremented, so the chain can never wrap to 59:59.
    assign w_dec0   = w_tick && !w_zero && !load;

    // A borrow out of the minutes tens would be an underflow; treat it as expiry
    // so the FSM can never keep running on a wrapped count.
    assign w_expire = w_at_one || w_borrow[3];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_presc   <= w_presc_n;
            r_running <= (w_state_n == RUN);
            r_done    <= (w_state_n == DONE);
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_presc_n = r_presc;

        if (load) begin
            w_state_n = IDLE;
            w_presc_n = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start_stop && !w_zero) begin
                        w_state_n = RUN;
                        w_presc_n = '0;
                    end
                end
                RUN: begin
                    // The prescaler advances on every RUN edge, including the
                    // pausing one; PAUSE then holds it so the partial second survives.
                    w_presc_n = w_tick ? '0 : (r_presc + 1'b1);
                    if (w_tick && w_expire) begin
                        w_state_n = DONE;
                    end else if (start_stop) begin
                        w_state_n = PAUSE;
                    end
                end
                PAUSE: begin
                    if (start_stop) begin
                        w_state_n = RUN;
                    end
                end
                DONE: begin
                    if (start_stop) begin
                        w_state_n = IDLE;
                    end
                end
                default: begin
                    w_state_n = IDLE;
                    w_presc_n = '0;
                end
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign count0  = w_dig0;
    assign count1  = w_dig1;
    assign count2  = w_dig2;
    assign count3  = w_dig3;
    assign running = r_running;
    assign done    = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    localparam int TPS = 4;
    localparam int PW  = 3;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       load = 1'b0;
    logic       start_stop = 1'b0;
    logic [3:0] preset0 = 4'd0;
    logic [3:0] preset1 = 4'd0;
    logic [3:0] preset2 = 4'd0;
    logic [3:0] preset3 = 4'd0;
    logic [3:0] count0;
    logic [3:0] count1;
    logic [3:0] count2;
    logic [3:0] count3;
    logic       running;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model: total seconds, cycles into current second, mode
    int m_secs  = 0;
    int m_phase = 0;
    int m_mode  = M_IDLE;

    countdown_timer #(.TICKS_PER_SEC(TPS), .PCW(PW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .load       (load),
        .start_stop (start_stop),
        .preset0    (preset0),
        .preset1    (preset1),
        .preset2    (preset2),
        .preset3    (preset3),
        .count0     (count0),
        .count1     (count1),
        .count2     (count2),
        .count3     (count3),
        .running    (running),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // {mm tens, mm units, ss tens, ss units} as 16-bit BCD, then running, done
    function automatic logic [31:0] model_vec();
        logic [3:0] d3, d2, d1, d0;
        d3 = 4'(m_secs / 600);
        d2 = 4'((m_secs / 60) % 10);
        d1 = 4'((m_secs % 60) / 10);
        d0 = 4'(m_secs % 10);
        return {14'd0, d3, d2, d1, d0, (m_mode == M_RUN), (m_mode == M_DONE)};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {14'd0, count3, count2, count1, count0, running, done};
    endfunction

    function automatic logic [31:0] vec(input logic [15:0] bcd, input logic r, input logic d);
        return {14'd0, bcd, r, d};
    endfunction

    task automatic model_reset();
        m_secs  = 0;
        m_phase = 0;
        m_mode  = M_IDLE;
    endtask

    task automatic model_step(input logic l, input logic s);
        if (l) begin
            m_secs = sat(int'(preset3), 5) * 600 + sat(int'(preset2), 9) * 60
                   + sat(int'(preset1), 5) * 10 + sat(int'(preset0), 9);
            m_phase = 0;
            m_mode  = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: if (s && m_secs > 0) begin
                    m_mode  = M_RUN;
                    m_phase = 0;
                end
                M_RUN: begin
                    m_phase++;
                    if (m_phase == TPS) begin
                        m_phase = 0;
                        m_secs--;
                        if (m_secs == 0) m_mode = M_DONE;
                        else if (s) m_mode = M_PAUSE;
                    end else if (s) begin
                        m_mode = M_PAUSE;
                    end
                end
                M_PAUSE: if (s) m_mode = M_RUN;
                M_DONE:  if (s) m_mode = M_IDLE;
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    task automatic step(input logic l, input logic s);
        load       = l;
        start_stop = s;
        @(posedge clk);
        model_step(l, s);
        #1;
        chk("cycle", dut_vec(), model_vec());
        load       = 1'b0;
        start_stop = 1'b0;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic set_preset(input logic [3:0] p3, input logic [3:0] p2,
                              input logic [3:0] p1, input logic [3:0] p0);
        preset3 = p3;
        preset2 = p2;
        preset1 = p1;
        preset0 = p0;
    endtask

    initial begin
        // reset
        rstn = 1'b0;
        #12;
        chk("reset", dut_vec(), vec(16'h0000, 1'b0, 1'b0));
        @(negedge clk);
        rstn = 1'b1;
        model_reset();

        // 00:10 full run to expiry
        set_preset(4'd0, 4'd0, 4'd1, 4'd0);
        step(1'b1, 1'b0);
        chk("load_0010", dut_vec(), vec(16'h0010, 1'b0, 1'b0));
        step(1'b0, 1'b1);
        chk("start_run", dut_vec(), vec(16'h0010, 1'b1, 1'b0));
        idle_n(3);
        chk("no_tick_yet", dut_vec(), vec(16'h0010, 1'b1, 1'b0));
        idle_n(1);
        chk("first_tick", dut_vec(), vec(16'h0009, 1'b1, 1'b0));
        idle_n(36);
        chk("expired", dut_vec(), vec(16'h0000, 1'b0, 1'b1));
        idle_n(6);
        chk("done_hold", dut_vec(), vec(16'h0000, 1'b0, 1'b1));

        // borrow chain
        set_preset(4'd0, 4'd1, 4'd0, 4'd0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        idle_n(4);
        chk("borrow_0100", dut_vec(), vec(16'h0059, 1'b1, 1'b0));
        set_preset(4'd1, 4'd0, 4'd0, 4'd0);
        step(1'b1, 1'b0);
        chk("load_1000", dut_vec(), vec(16'h1000, 1'b0, 1'b0));
        step(1'b0, 1'b1);
        idle_n(4);
        chk("borrow_1000", dut_vec(), vec(16'h0959, 1'b1, 1'b0));

        // pause keeps partial second
        set_preset(4'd0, 4'd0, 4'd0, 4'd5);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        idle_n(5);
        step(1'b0, 1'b1);
        chk("paused", dut_vec(), vec(16'h0004, 1'b0, 1'b0));
        idle_n(20);
        chk("pause_hold", dut_vec(), vec(16'h0004, 1'b0, 1'b0));
        step(1'b0, 1'b1);
        idle_n(1);
        chk("resume_partial", dut_vec(), vec(16'h0004, 1'b1, 1'b0));
        idle_n(1);
        chk("resume_tick", dut_vec(), vec(16'h0003, 1'b1, 1'b0));

        // saturation and start from 00:00
        set_preset(4'hF, 4'hF, 4'hF, 4'hF);
        step(1'b1, 1'b0);
        chk("saturate", dut_vec(), vec(16'h5959, 1'b0, 1'b0));
        set_preset(4'd0, 4'd0, 4'd0, 4'd0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("start_at_zero", dut_vec(), vec(16'h0000, 1'b0, 1'b0));
        idle_n(5);
        chk("zero_stays_idle", dut_vec(), vec(16'h0000, 1'b0, 1'b0));

        // load beats start_stop; acknowledge expiry
        set_preset(4'd0, 4'd0, 4'd3, 4'd0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        idle_n(2);
        set_preset(4'd0, 4'd0, 4'd0, 4'd2);
        step(1'b1, 1'b1);
        chk("load_priority", dut_vec(), vec(16'h0002, 1'b0, 1'b0));
        step(1'b0, 1'b1);
        idle_n(8);
        chk("short_expire", dut_vec(), vec(16'h0000, 1'b0, 1'b1));
        step(1'b0, 1'b1);
        chk("ack_done", dut_vec(), vec(16'h0000, 1'b0, 1'b0));

        // tick and start_stop on the same edge
        set_preset(4'd0, 4'd0, 4'd0, 4'd3);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        idle_n(3);
        step(1'b0, 1'b1);
        chk("tick_and_pause", dut_vec(), vec(16'h0002, 1'b0, 1'b0));

        // async reset mid-run
        set_preset(4'd0, 4'd3, 4'd2, 4'd7);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        idle_n(3);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_reset", dut_vec(), vec(16'h0000, 1'b0, 1'b0));
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        idle_n(2);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic l, s;
            l = ($urandom_range(0, 39) == 0);
            s = ($urandom_range(0, 9) == 0);
            if (l) begin
                preset0 = 4'($urandom_range(0, 15));
                preset1 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
                preset2 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
                preset3 = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            end
            step(l, s);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
